// File: rtl/sram_ctrl_pkg.sv
// Shared definitions for the SRAM request front-end and its response FIFO.
package sram_ctrl_pkg;

   // Default geometry: 32-bit words with bit enables, 64-word memory, 2-entry response FIFO
   localparam int DEF_DW        = 32;
   localparam int DEF_AW        = 6;
   localparam int DEF_RSP_DEPTH = 2;

   // Replicated to full data width to form the all-ones bit enable used by zeroize
   localparam bit BE_ON = 1'b1;

   // Controller modes: serving requests, or sweeping the whole array with zeros
   typedef enum logic {
      IDLE = 1'b0,
      ZERO = 1'b1
   } state_t;

endpackage

// File: rtl/sram_rsp_fifo.sv
// Synchronous response FIFO holding SRAM read data until the consumer takes it.
module sram_rsp_fifo #(
   parameter int DW    = 32,
   parameter int DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [DW-1:0]            push_data,
   input  logic                     pop,
   output logic [DW-1:0]            rd_data,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [DW-1:0] store [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic          do_pop;
   logic          full;

   assign do_pop  = pop && (count != '0);
   assign full    = (count == CW'(DEPTH));
   assign rd_data = store[rd_ptr];

   // Pointers wrap naturally because DEPTH is a power of two; count tracks occupancy
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + PW'(1);
         if (do_pop)
            rd_ptr <= rd_ptr + PW'(1);
         if (push && !do_pop)
            count <= count + CW'(1);
         else if (!push && do_pop)
            count <= count - CW'(1);
      end
   end

   // Data storage needs no reset; only entries covered by count are ever visible
   always_ff @(posedge clk) begin
      if (push)
         store[wr_ptr] <= push_data;
   end

   // Upstream credit accounting must make a push into a full FIFO impossible
   always_ff @(posedge clk) begin
      if (!rst)
         assert (!(push && full));
   end

endmodule

// File: rtl/sram_req_ctrl.sv
// Request front-end for the single-port bit-enable SRAM: request steering,
// read-response capture with credit-based backpressure, and a zeroize sweep.
module sram_req_ctrl
   import sram_ctrl_pkg::*;
#(
   parameter int DW        = DEF_DW,
   parameter int AW        = DEF_AW,
   parameter int RSP_DEPTH = DEF_RSP_DEPTH
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic          req_we,
   input  logic [AW-1:0] req_addr,
   input  logic [DW-1:0] req_wdata,
   input  logic [DW-1:0] req_be,
   output logic          rsp_valid,
   input  logic          rsp_ready,
   output logic [DW-1:0] rsp_rdata,
   input  logic          zero_start,
   output logic          zero_busy,
   output logic          zero_done,
   output logic          mem_cs,
   output logic          mem_we,
   output logic [DW-1:0] mem_be,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_din,
   input  logic [DW-1:0] mem_dout
);

   typedef logic [AW-1:0] addr_t;
   typedef logic [DW-1:0] data_t;

   localparam int    CW        = $clog2(RSP_DEPTH) + 1;
   localparam data_t BE_ALL    = {DW{BE_ON}};
   localparam addr_t ZERO_LAST = {AW{1'b1}};

   state_t        state;
   state_t        state_n;
   addr_t         zero_cnt;
   addr_t         zero_cnt_n;
   logic          zero_done_n;
   logic          inflight;
   logic          rd_acc;
   logic          pop;
   logic          rd_credit;
   logic [CW-1:0] fifo_count;
   logic [CW:0]   occupancy;

   assign rsp_valid = (fifo_count != '0);
   assign pop       = rsp_valid && rsp_ready;
   assign zero_busy = (state == ZERO);
   assign rd_acc    = req_valid && req_ready && !req_we;

   // A read may issue only if every slot it could need is guaranteed free,
   // counting the entry leaving this cycle and the read already in the SRAM pipe
   assign occupancy = {1'b0, fifo_count} + (CW+1)'(inflight) - (CW+1)'(pop);
   assign rd_credit = occupancy < (CW+1)'(RSP_DEPTH);

   // Mode selection and SRAM pin steering: pass-through of the request in IDLE,
   // one zero-write per cycle in ZERO; nothing reaches the macro during reset
   always_comb begin
      state_n     = state;
      zero_cnt_n  = zero_cnt;
      zero_done_n = 1'b0;
      req_ready   = 1'b0;
      mem_cs      = 1'b0;
      mem_we      = 1'b0;
      mem_be      = '0;
      mem_addr    = '0;
      mem_din     = '0;
      unique case (state)
         IDLE: begin
            req_ready = !rst && !zero_start && (req_we || rd_credit);
            mem_cs    = req_valid && req_ready;
            mem_we    = req_we;
            mem_be    = req_be;
            mem_addr  = req_addr;
            mem_din   = req_wdata;
            if (zero_start) begin
               state_n    = ZERO;
               zero_cnt_n = '0;
            end
         end
         ZERO: begin
            mem_cs     = !rst;
            mem_we     = 1'b1;
            mem_be     = BE_ALL;
            mem_addr   = zero_cnt;
            mem_din    = '0;
            zero_cnt_n = zero_cnt + AW'(1);
            if (zero_cnt == ZERO_LAST) begin
               state_n     = IDLE;
               zero_done_n = 1'b1;
            end
         end
      endcase
   end

   // State, sweep counter, completion pulse and the one-deep read pipeline marker
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         zero_cnt  <= '0;
         zero_done <= 1'b0;
         inflight  <= 1'b0;
      end else begin
         state     <= state_n;
         zero_cnt  <= zero_cnt_n;
         zero_done <= zero_done_n;
         inflight  <= rd_acc;
      end
   end

   sram_rsp_fifo #(
      .DW    (DW),
      .DEPTH (RSP_DEPTH)
   ) u_rsp_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (inflight),
      .push_data (mem_dout),
      .pop       (pop),
      .rd_data   (rsp_rdata),
      .count     (fifo_count)
   );

endmodule

// File: tb/tb_sram_req_ctrl.sv
// Directed self-checking bench for sram_req_ctrl with a behavioural SRAM model.
module tb_sram_req_ctrl;

   localparam int DW        = 32;
   localparam int AW        = 6;
   localparam int RSP_DEPTH = 2;
   localparam int WORDS     = 2**AW;

   logic          clk = 1'b0;
   logic          rst;
   logic          req_valid;
   logic          req_ready;
   logic          req_we;
   logic [AW-1:0] req_addr;
   logic [DW-1:0] req_wdata;
   logic [DW-1:0] req_be;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [DW-1:0] rsp_rdata;
   logic          zero_start;
   logic          zero_busy;
   logic          zero_done;
   logic          mem_cs;
   logic          mem_we;
   logic [DW-1:0] mem_be;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_din;
   logic [DW-1:0] mem_dout;

   logic [DW-1:0] sram [WORDS];

   int total  = 0;
   int passed = 0;
   int failed = 0;

   // Free-running 10 ns clock
   always #5 clk = ~clk;

   sram_req_ctrl #(
      .DW        (DW),
      .AW        (AW),
      .RSP_DEPTH (RSP_DEPTH)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .req_be     (req_be),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_rdata  (rsp_rdata),
      .zero_start (zero_start),
      .zero_busy  (zero_busy),
      .zero_done  (zero_done),
      .mem_cs     (mem_cs),
      .mem_we     (mem_we),
      .mem_be     (mem_be),
      .mem_addr   (mem_addr),
      .mem_din    (mem_din),
      .mem_dout   (mem_dout)
   );

   // Single-port SRAM with per-bit write enable and one-cycle read latency
   always @(posedge clk) begin
      if (mem_cs) begin
         if (mem_we)
            sram[mem_addr] <= (sram[mem_addr] & ~mem_be) | (mem_din & mem_be);
         else
            mem_dout <= sram[mem_addr];
      end
   end

   // Hard stop in case the directed sequence ever stalls
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: observed timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic applyStimulus(input logic valid, input logic we, input logic [AW-1:0] addr,
                                input logic [DW-1:0] wdata, input logic [DW-1:0] be);
      req_valid = valid;
      req_we    = we;
      req_addr  = addr;
      req_wdata = wdata;
      req_be    = be;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      total++;
      assert (observed === expected) passed++;
      else begin
         failed++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   // One accepted write, leaving the bench one cycle later with the request dropped
   task automatic doWrite(input logic [AW-1:0] addr, input logic [DW-1:0] data, input logic [DW-1:0] be);
      applyStimulus(1'b1, 1'b1, addr, data, be);
      settle();
      checkOutput("wr_ready", 32'(req_ready), 32'd1);
      cyc();
      applyStimulus(1'b0, 1'b0, '0, '0, '0);
   endtask

   // Isolated read with rsp_ready high: response expected two cycles after accept
   task automatic doReadCheck(input logic [AW-1:0] addr, input logic [DW-1:0] expected, input string tag);
      applyStimulus(1'b1, 1'b0, addr, '0, '0);
      settle();
      checkOutput({tag, "_ready"}, 32'(req_ready), 32'd1);
      cyc();
      applyStimulus(1'b0, 1'b0, '0, '0, '0);
      settle();
      checkOutput({tag, "_early"}, 32'(rsp_valid), 32'd0);
      cyc();
      settle();
      checkOutput({tag, "_valid"}, 32'(rsp_valid), 32'd1);
      checkOutput({tag, "_data"}, rsp_rdata, expected);
      cyc();
   endtask

   initial begin
      for (int i = 0; i < WORDS; i++)
         sram[i] = '0;
      mem_dout   = '0;
      rst        = 1'b1;
      zero_start = 1'b0;
      rsp_ready  = 1'b1;
      applyStimulus(1'b1, 1'b1, 6'd5, 32'h1234_5678, '1);

      // Reset: nothing accepted, nothing reaches the SRAM
      cyc();
      settle();
      checkOutput("rst_req_ready", 32'(req_ready), 32'd0);
      checkOutput("rst_mem_cs", 32'(mem_cs), 32'd0);
      cyc();
      settle();
      checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      checkOutput("rst_zero_busy", 32'(zero_busy), 32'd0);
      checkOutput("rst_zero_done", 32'(zero_done), 32'd0);
      rst = 1'b0;
      applyStimulus(1'b0, 1'b0, '0, '0, '0);
      cyc();

      // Plain write then read-back
      applyStimulus(1'b1, 1'b1, 6'd5, 32'hDEAD_BEEF, '1);
      settle();
      checkOutput("t1_wr_cs", 32'(mem_cs), 32'd1);
      checkOutput("t1_wr_we", 32'(mem_we), 32'd1);
      cyc();
      applyStimulus(1'b0, 1'b0, '0, '0, '0);
      doReadCheck(6'd5, 32'hDEAD_BEEF, "t1_rd");
      settle();
      checkOutput("t1_drained", 32'(rsp_valid), 32'd0);

      // Bit-enable partial write keeps the unmasked upper half
      doWrite(6'd3, 32'hFFFF_FFFF, '1);
      doWrite(6'd3, 32'h0000_0000, 32'h0000_FFFF);
      doReadCheck(6'd3, 32'hFFFF_0000, "t2_rd");

      // Back-to-back reads at one per cycle
      for (int i = 0; i < 4; i++)
         doWrite(AW'(i), 32'h10 + 32'(i), '1);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, 1'b0, AW'(i), '0, '0);
         settle();
         checkOutput("t3_ready", 32'(req_ready), 32'd1);
         if (i >= 2) begin
            checkOutput("t3_valid", 32'(rsp_valid), 32'd1);
            checkOutput("t3_data", rsp_rdata, 32'h10 + 32'(i - 2));
         end else begin
            checkOutput("t3_not_yet", 32'(rsp_valid), 32'd0);
         end
         cyc();
      end
      applyStimulus(1'b0, 1'b0, '0, '0, '0);
      settle();
      checkOutput("t3_data2", rsp_rdata, 32'h12);
      cyc();
      settle();
      checkOutput("t3_valid3", 32'(rsp_valid), 32'd1);
      checkOutput("t3_data3", rsp_rdata, 32'h13);
      cyc();
      settle();
      checkOutput("t3_drained", 32'(rsp_valid), 32'd0);

      // Backpressure: only RSP_DEPTH reads get credit, writes still flow
      rsp_ready = 1'b0;
      applyStimulus(1'b1, 1'b0, 6'd0, '0, '0);
      settle();
      checkOutput("t4_rd0_ready", 32'(req_ready), 32'd1);
      cyc();
      applyStimulus(1'b1, 1'b0, 6'd1, '0, '0);
      settle();
      checkOutput("t4_rd1_ready", 32'(req_ready), 32'd1);
      cyc();
      applyStimulus(1'b1, 1'b0, 6'd2, '0, '0);
      settle();
      checkOutput("t4_rd2_blocked", 32'(req_ready), 32'd0);
      checkOutput("t4_rd2_no_cs", 32'(mem_cs), 32'd0);
      cyc();
      settle();
      checkOutput("t4_rd2_still_blocked", 32'(req_ready), 32'd0);
      checkOutput("t4_head_valid", 32'(rsp_valid), 32'd1);
      checkOutput("t4_head_data", rsp_rdata, 32'h10);
      cyc();
      applyStimulus(1'b1, 1'b1, 6'd40, 32'hAAAA_5555, '1);
      settle();
      checkOutput("t4_wr_ready", 32'(req_ready), 32'd1);
      cyc();
      rsp_ready = 1'b1;
      applyStimulus(1'b1, 1'b0, 6'd2, '0, '0);
      settle();
      checkOutput("t4_rd2_ready", 32'(req_ready), 32'd1);
      checkOutput("t4_rsp0", rsp_rdata, 32'h10);
      cyc();
      applyStimulus(1'b1, 1'b0, 6'd3, '0, '0);
      settle();
      checkOutput("t4_rd3_ready", 32'(req_ready), 32'd1);
      checkOutput("t4_rsp1", rsp_rdata, 32'h11);
      cyc();
      applyStimulus(1'b0, 1'b0, '0, '0, '0);
      settle();
      checkOutput("t4_rsp2_valid", 32'(rsp_valid), 32'd1);
      checkOutput("t4_rsp2", rsp_rdata, 32'h12);
      cyc();
      settle();
      checkOutput("t4_rsp3_valid", 32'(rsp_valid), 32'd1);
      checkOutput("t4_rsp3", rsp_rdata, 32'h13);
      cyc();
      settle();
      checkOutput("t4_drained", 32'(rsp_valid), 32'd0);
      doReadCheck(6'd40, 32'hAAAA_5555, "t4_wr_rd");

      // Full zeroize sweep, with a read held pending the whole time
      for (int i = 0; i < WORDS; i++)
         doWrite(AW'(i), 32'hA5A5_0000 | 32'(i), '1);
      zero_start = 1'b1;
      applyStimulus(1'b1, 1'b0, 6'd7, '0, '0);
      settle();
      checkOutput("t5_start_ready", 32'(req_ready), 32'd0);
      checkOutput("t5_start_cs", 32'(mem_cs), 32'd0);
      checkOutput("t5_start_busy", 32'(zero_busy), 32'd0);
      cyc();
      zero_start = 1'b0;
      for (int i = 0; i < WORDS; i++) begin
         settle();
         checkOutput("t5_busy", 32'(zero_busy), 32'd1);
         checkOutput("t5_ready", 32'(req_ready), 32'd0);
         checkOutput("t5_addr", 32'(mem_addr), 32'(i));
         checkOutput("t5_din", mem_din, 32'h0);
         if (i == 0) begin
            checkOutput("t5_cs", 32'(mem_cs), 32'd1);
            checkOutput("t5_we", 32'(mem_we), 32'd1);
            checkOutput("t5_be", mem_be, 32'hFFFF_FFFF);
            checkOutput("t5_no_done", 32'(zero_done), 32'd0);
         end
         cyc();
      end
      applyStimulus(1'b0, 1'b0, '0, '0, '0);
      settle();
      checkOutput("t5_done", 32'(zero_done), 32'd1);
      checkOutput("t5_busy_off", 32'(zero_busy), 32'd0);
      cyc();
      settle();
      checkOutput("t5_done_once", 32'(zero_done), 32'd0);
      doReadCheck(6'd0, 32'h0, "t5_rd0");
      doReadCheck(6'd31, 32'h0, "t5_rd31");
      doReadCheck(6'd63, 32'h0, "t5_rd63");

      // Reset in the middle of a sweep with a full response FIFO
      for (int i = 0; i < WORDS; i++)
         doWrite(AW'(i), 32'hC0DE_0000 | 32'(i), '1);
      rsp_ready = 1'b0;
      applyStimulus(1'b1, 1'b0, 6'd1, '0, '0);
      settle();
      cyc();
      applyStimulus(1'b1, 1'b0, 6'd2, '0, '0);
      settle();
      checkOutput("t6_rd2_ready", 32'(req_ready), 32'd1);
      cyc();
      applyStimulus(1'b0, 1'b0, '0, '0, '0);
      cyc();
      zero_start = 1'b1;
      settle();
      checkOutput("t6_fifo_valid", 32'(rsp_valid), 32'd1);
      checkOutput("t6_fifo_head", rsp_rdata, 32'hC0DE_0001);
      cyc();
      zero_start = 1'b0;
      repeat (20) cyc();
      settle();
      checkOutput("t6_addr20", 32'(mem_addr), 32'd20);
      checkOutput("t6_busy20", 32'(zero_busy), 32'd1);
      rst = 1'b1;
      settle();
      checkOutput("t6_rst_cs", 32'(mem_cs), 32'd0);
      cyc();
      rst = 1'b0;
      settle();
      checkOutput("t6_rsp_flushed", 32'(rsp_valid), 32'd0);
      checkOutput("t6_busy_cleared", 32'(zero_busy), 32'd0);
      checkOutput("t6_no_done", 32'(zero_done), 32'd0);
      cyc();
      settle();
      checkOutput("t6_no_done_later", 32'(zero_done), 32'd0);
      rsp_ready = 1'b1;
      doReadCheck(6'd21, 32'hC0DE_0015, "t6_rd21");
      doReadCheck(6'd20, 32'hC0DE_0014, "t6_rd20");
      doReadCheck(6'd19, 32'h0, "t6_rd19");

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/sram_req_ctrl.md
Name: sram_req_ctrl

Overview:
- Request front-end that sits directly upstream of the single-port bit-enable SRAM macro/model in the mini crypto accelerator.
- Converts a valid/ready read/write request stream into the SRAM cs/we/be/addr/din pins.
- Captures the 1-cycle-latency read data into a response FIFO with full backpressure.
- Provides a zeroize sequencer that clears all 2**AW words, used for key/state memories.

Parameters:
DW, 32, data width and bit-enable width
AW, 6, address width; memory depth is 2**AW words
RSP_DEPTH, 2, response FIFO entries (power of two, >=2)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
req_valid  in  1  request valid
req_ready  out  1  request accepted when valid&ready
req_we  in  1  1=write, 0=read
req_addr  in  AW  word address
req_wdata  in  DW  write data
req_be  in  DW  per-bit write enable
rsp_valid  out  1  read data valid
rsp_ready  in  1  consumer ready
rsp_rdata  out  DW  read data
zero_start  in  1  one-cycle pulse to start zeroize
zero_busy  out  1  zeroize in progress
zero_done  out  1  one-cycle pulse when zeroize completes
mem_cs  out  1  SRAM chip select
mem_we  out  1  SRAM write enable
mem_be  out  DW  SRAM bit enable
mem_addr  out  AW  SRAM address
mem_din  out  DW  SRAM write data
mem_dout  in  DW  SRAM read data, valid the cycle after a read cs

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values: rsp_valid=0, FIFO empty (rd/wr ptr=0, count=0), inflight=0, state=IDLE, zero_busy=0, zero_done=0, zero address counter=0.
- Pins under reset: mem_cs=0 and req_ready=0 while rst=1.
- FSM states: IDLE, ZERO.
  - IDLE→ZERO on zero_start=1.
  - ZERO→IDLE after the write to address 2**AW-1.
  - zero_start is ignored in ZERO.
- IDLE pin drive: SRAM pins are driven combinationally from the request. mem_cs = req_valid&req_ready; mem_we=req_we; mem_be=req_be; mem_addr=req_addr; mem_din=req_wdata.
- Write acceptance: writes produce no response. req_ready for a write = IDLE & !zero_start.
- Read acceptance: req_ready for a read = IDLE & !zero_start & (count + inflight - pop) < RSP_DEPTH, where pop = rsp_valid&rsp_ready. The rsp_ready→req_ready path is combinational by design.
- Read latency: read accepted in cycle N → inflight=1 in N+1 → mem_dout pushed into FIFO at end of N+1 → rsp_valid=1 in cycle N+2 at the earliest.
- Throughput: 1 read/cycle sustained when rsp_ready=1 and RSP_DEPTH>=2.
- inflight: set on read accept, cleared the next cycle (the push cycle). Set and clear in the same cycle leaves inflight=1.
- FIFO: push and pop in the same cycle keep count unchanged. Pointers wrap modulo RSP_DEPTH. rsp_rdata = mem[rd_ptr]. Overflow is impossible by the credit rule; a push at full is an assertion failure.
- Ordering: responses are returned strictly in request order. A write after a read to the same address does not affect the earlier read's data.
- ZERO state:
  - req_ready=0.
  - Each cycle: mem_cs=1, mem_we=1, mem_be=all-ones, mem_din=0, mem_addr=counter. Counter increments 0..2**AW-1.
  - zero_busy=1 from the cycle after zero_start through the last write cycle.
  - zero_done=1 for exactly one cycle after the last write; state is IDLE in that cycle.
  - Duration: 2**AW cycles.
- Zeroize with a read in flight: a read accepted the cycle before zero_start still completes normally. Its response enters the FIFO, and rsp handshake continues during ZERO.
- zero_start and req_valid in the same cycle: zeroize wins and the request is not accepted.
- rst mid-operation: any in-flight read is discarded, FIFO is flushed, zeroize is aborted with no zero_done, and the counter returns to 0.
- mem_cs is never asserted for more than one access per cycle. Reads never set mem_we.

Decomposition:
- Shared package sram_ctrl_pkg:
  - state enum {IDLE, ZERO};
  - typedefs for addr_t (AW) and data_t (DW), parameterised via the module;
  - constant for the all-ones bit-enable.
- One natural sub-module: sram_rsp_fifo (synchronous FIFO, depth RSP_DEPTH, with count output and push/pop).
- The FSM and credit logic stay in the top.

Test Plan:
1. Write 0xDEADBEEF to addr 5 with be=all-ones, then read addr 5 with rsp_ready=1 → rsp_valid 2 cycles after read accept, rsp_rdata=0xDEADBEEF.
2. Write 0xFFFFFFFF to addr 3, then write 0x00000000 with be=0x0000FFFF, then read addr 3 → 0xFFFF0000.
3. Back-to-back reads of addr 0,1,2,3 (pre-written 0x10..0x13) with rsp_ready=1 → req_ready held 1, responses 0x10,0x11,0x12,0x13 on consecutive cycles.
4. Hold rsp_ready=0 and issue 4 reads → exactly 2 accepted, req_ready=0 for reads while a write is still accepted. Release rsp_ready → 2 responses in order, then the remaining reads proceed.
5. Fill memory with nonzero data, pulse zero_start → zero_busy for 64 cycles with req_ready=0, zero_done pulses once, then reads of addr 0, 31, 63 all return 0.
6. Assert rst during ZERO (counter=20) and with a full FIFO → next cycle rsp_valid=0, zero_busy=0, no zero_done, addr 21 keeps its prior value.
